// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard / control-transfer controller.
// Detects RAW hazards against EX and MEM write-backs, handles taken branches,
// and sequences interrupt entry (accept, 2-cycle drain, inject).
module pipeline_hazard_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [4:0]  id_src_x,
  input  logic [4:0]  id_src_y,
  input  logic        id_uses_x,
  input  logic        id_uses_y,
  input  logic        ex_rf_wr,
  input  logic [4:0]  ex_wb_addr,
  input  logic        mem_rf_wr,
  input  logic [4:0]  mem_wb_addr,
  input  logic        br_taken,
  input  logic        int_req,
  input  logic        i_flag,
  output logic        stall_if,
  output logic        flush_if,
  output logic        nop_id,
  output logic        int_inject,
  output logic        int_ack,
  output logic [1:0]  state_dbg,
  output logic [15:0] stall_cycles
);

  localparam logic [1:0] RUN    = 2'd0;
  localparam logic [1:0] FLUSH  = 2'd1;
  localparam logic [1:0] DRAIN  = 2'd2;
  localparam logic [1:0] INJECT = 2'd3;

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic       drain_cnt;
  logic       drain_cnt_nxt;
  logic       hazard;
  logic       hit_x;
  logic       hit_y;
  logic       stall_inc;

  // RAW hazard: a used source matches an enabled EX or MEM write-back (r0 included)
  always_comb begin
    hit_x  = id_uses_x && ((ex_rf_wr  && (id_src_x == ex_wb_addr)) ||
                           (mem_rf_wr && (id_src_x == mem_wb_addr)));
    hit_y  = id_uses_y && ((ex_rf_wr  && (id_src_y == ex_wb_addr)) ||
                           (mem_rf_wr && (id_src_y == mem_wb_addr)));
    hazard = id_valid && (hit_x || hit_y);
  end

  // Next-state and output decode; outputs held low while reset is asserted
  always_comb begin
    state_nxt     = state;
    drain_cnt_nxt = drain_cnt;
    stall_if      = 1'b0;
    flush_if      = 1'b0;
    nop_id        = 1'b0;
    int_inject    = 1'b0;
    int_ack       = 1'b0;
    stall_inc     = 1'b0;
    if (!rst) begin
      case (state)
        RUN: begin
          if (br_taken) begin
            flush_if  = 1'b1;
            nop_id    = 1'b1;
            state_nxt = FLUSH;
          end else if (hazard) begin
            stall_if  = 1'b1;
            nop_id    = 1'b1;
            stall_inc = 1'b1;
          end else if (int_req && i_flag) begin
            stall_if      = 1'b1;
            nop_id        = 1'b1;
            drain_cnt_nxt = 1'b1;
            state_nxt     = DRAIN;
          end
        end
        FLUSH: begin
          flush_if  = 1'b1;
          nop_id    = 1'b1;
          state_nxt = RUN;
        end
        DRAIN: begin
          if (br_taken) begin
            flush_if      = 1'b1;
            nop_id        = 1'b1;
            drain_cnt_nxt = 1'b0;
            state_nxt     = FLUSH;
          end else begin
            stall_if = 1'b1;
            nop_id   = 1'b1;
            if (drain_cnt) drain_cnt_nxt = 1'b0;
            else           state_nxt     = INJECT;
          end
        end
        default: begin
          int_inject = 1'b1;
          stall_if   = 1'b1;
          int_ack    = 1'b1;
          state_nxt  = RUN;
        end
      endcase
    end
  end

  // State, drain counter and saturating stall counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= RUN;
      drain_cnt    <= 1'b0;
      stall_cycles <= '0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= drain_cnt_nxt;
      if (stall_inc && (stall_cycles != '1))
        stall_cycles <= stall_cycles + 16'd1;
    end
  end

  assign state_dbg = state;

endmodule
